// File: rtl/matrix_op_sequencer_if.sv
// Host-side handshakes of the matrix ALU sequencer: command, operand stream and result stream.
// MATRIX_SEQ_OPERAND_REUSE_EN adds cmd_reuse to the command channel.
interface matrix_op_sequencer_if #(
  parameter int ELEM_W = 8
);
  logic              cmd_valid;
  logic              cmd_ready;
  logic [2:0]        cmd_opcode;
  logic [7:0]        cmd_scalar;
  logic              cmd_err;
`ifdef MATRIX_SEQ_OPERAND_REUSE_EN
  logic              cmd_reuse;
`endif
  logic              in_valid;
  logic              in_ready;
  logic [ELEM_W-1:0] in_data;
  logic              out_valid;
  logic              out_ready;
  logic [ELEM_W-1:0] out_data;
  logic              out_last;
  logic              out_ovf;

  modport master (
`ifdef MATRIX_SEQ_OPERAND_REUSE_EN
    output cmd_reuse,
`endif
    output cmd_valid, cmd_opcode, cmd_scalar,
    input  cmd_ready, cmd_err,
    output in_valid, in_data,
    input  in_ready,
    input  out_valid, out_data, out_last, out_ovf,
    output out_ready
  );

  modport slave (
`ifdef MATRIX_SEQ_OPERAND_REUSE_EN
    input  cmd_reuse,
`endif
    input  cmd_valid, cmd_opcode, cmd_scalar,
    output cmd_ready, cmd_err,
    input  in_valid, in_data,
    output in_ready,
    output out_valid, out_data, out_last, out_ovf,
    input  out_ready
  );
endinterface

// File: rtl/matrix_op_sequencer.sv
// Byte-serial front/back end for the 5x5 matrix ALU: load A/B, issue, settle, capture, stream C.
// Optional MATRIX_SEQ_OPERAND_REUSE_EN: cmd_reuse skips operand loading and reuses held A/B.
module matrix_op_sequencer #(
  parameter int ELEM_W = 8,
  parameter int N_ELEM = 25,
  parameter int SETTLE = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  matrix_op_sequencer_if.slave     bus,
  output logic [ELEM_W*N_ELEM-1:0] alu_A_flat,
  output logic [ELEM_W*N_ELEM-1:0] alu_B_flat,
  output logic [7:0]               alu_f,
  output logic [2:0]               alu_opcode,
  input  logic [ELEM_W*N_ELEM-1:0] alu_C_flat,
  input  logic                     alu_ovf,
  output logic                     busy
);
  localparam int               CNT_W = $clog2(N_ELEM);
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(N_ELEM - 1);

  typedef enum logic [2:0] {IDLE, LOAD_A, LOAD_B, ISSUE, SETTLE_W, STREAM} state_t;
  state_t state, state_nx;

  logic [CNT_W-1:0]              cnt;
  logic [3:0]                    settle_cnt;
  logic [2:0]                    op_q;
  logic [7:0]                    f_q;
  logic                          ovf_q, cmd_err_q;
  logic [N_ELEM-1:0][ELEM_W-1:0] a_q, b_q, res_q;

  logic op_ok, op_bin, reuse, in_beat, out_beat, last_cnt;

  assign op_ok    = bus.cmd_opcode inside {3'b001, 3'b010, 3'b100, 3'b101, 3'b110};
  assign op_bin   = op_q inside {3'b001, 3'b010};
  assign last_cnt = (cnt == LAST);
  assign in_beat  = (state == LOAD_A || state == LOAD_B) && bus.in_valid;
  assign out_beat = (state == STREAM) && bus.out_ready;

`ifdef MATRIX_SEQ_OPERAND_REUSE_EN
  assign reuse = bus.cmd_reuse;
`else
  assign reuse = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:     if (bus.cmd_valid && op_ok) state_nx = reuse ? ISSUE : LOAD_A;
      LOAD_A:   if (in_beat && last_cnt) state_nx = op_bin ? LOAD_B : ISSUE;
      LOAD_B:   if (in_beat && last_cnt) state_nx = ISSUE;
      ISSUE:    state_nx = SETTLE_W;
      SETTLE_W: if (settle_cnt == 4'd0) state_nx = STREAM;
      STREAM:   if (out_beat && last_cnt) state_nx = IDLE;
      default:  state_nx = IDLE;
    endcase
  end

  // The ALU evaluates on opcode change, so alu_opcode returns to 000 outside ISSUE/SETTLE_W.
  always_comb begin
    bus.cmd_ready = 1'b0;
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    bus.out_last  = 1'b0;
    bus.out_data  = '0;
    alu_opcode    = 3'b000;
    busy          = 1'b1;
    case (state)
      IDLE:             begin bus.cmd_ready = 1'b1; busy = 1'b0; end
      LOAD_A, LOAD_B:   bus.in_ready = 1'b1;
      ISSUE, SETTLE_W:  alu_opcode = op_q;
      STREAM: begin
        bus.out_valid = 1'b1;
        bus.out_last  = last_cnt;
        bus.out_data  = res_q[cnt];
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      cnt        <= '0;
      settle_cnt <= '0;
      op_q       <= '0;
      f_q        <= '0;
      ovf_q      <= 1'b0;
      cmd_err_q  <= 1'b0;
      a_q        <= '0;
      b_q        <= '0;
      res_q      <= '0;
    end else begin
      cmd_err_q <= 1'b0;
      case (state)
        IDLE: if (bus.cmd_valid) begin
          if (op_ok) begin
            op_q <= bus.cmd_opcode;
            f_q  <= bus.cmd_scalar;
            cnt  <= '0;
          end else begin
            cmd_err_q <= 1'b1;
          end
        end
        LOAD_A, LOAD_B: if (in_beat) begin
          if (state == LOAD_A) a_q[cnt] <= bus.in_data;
          else                 b_q[cnt] <= bus.in_data;
          cnt <= last_cnt ? '0 : cnt + 1'b1;
        end
        ISSUE: settle_cnt <= 4'(SETTLE - 1);
        SETTLE_W: begin
          if (settle_cnt == 4'd0) begin
            res_q <= alu_C_flat;
            ovf_q <= alu_ovf;
            cnt   <= '0;
          end else begin
            settle_cnt <= settle_cnt - 1'b1;
          end
        end
        STREAM: if (out_beat) cnt <= last_cnt ? '0 : cnt + 1'b1;
        default: ;
      endcase
    end

  assign bus.cmd_err = cmd_err_q;
  assign bus.out_ovf = ovf_q;
  assign alu_A_flat  = a_q;
  assign alu_B_flat  = b_q;
  assign alu_f       = f_q;
endmodule
